// File: rtl/i2c_rst_sequencer.sv
// Reset sequencer: PE reset wraps core reset, round-robin request service.
// Ports: clk, rst_n, req/ack per source, rst_out, pe_rst_out, busy;
//   seq_count[7:0] only when I2C_RST_SEQ_STATUS_EN is defined.
module i2c_rst_sequencer #(
  parameter int N_REQ = 3,
  parameter logic [N_REQ-1:0] FULL_MASK = 3'b001,
  parameter int RST_HOLD = 8,
  parameter int PE_LAG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             rst_out,
  output logic             pe_rst_out,
  output logic             busy
`ifdef I2C_RST_SEQ_STATUS_EN
  ,
  output logic [7:0]       seq_count
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [7:0] HOLD_LD = 8'(RST_HOLD - 1);
  localparam logic [7:0] LAG_LD = 8'(PE_LAG - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [2:0] {
    IDLE,
    PE_ON,
    CORE_HOLD,
    PE_HOLD,
    DONE
  } state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [N_REQ-1:0]  pend;
  logic [IW-1:0]     rr;
  logic [IW-1:0]     grant;
  logic              gvalid;

  logic [N_REQ-1:0]  rot;
  logic [N_REQ-1:0]  clr;
  logic              found;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     nxt;
  int                sum;

  // Rotate pending so the search starts at rr; lowest set bit wins.
  always_comb begin
    rot = (pend >> rr) | (pend << (N_REQ - int'(rr)));
    found = 1'b0;
    sum = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum = int'(rr) + k;
      end
    end
    if (sum >= N_REQ) sum = sum - N_REQ;
    pick = IW'(sum);
    nxt = (sum == N_REQ - 1) ? '0 : IW'(sum + 1);
    clr = (state == IDLE && found) ? (ONE << pick) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CORE_HOLD;
      cnt        <= HOLD_LD;
      pend       <= '0;
      rr         <= '0;
      grant      <= '0;
      gvalid     <= 1'b0;
      ack        <= '0;
      rst_out    <= 1'b1;
      pe_rst_out <= 1'b1;
      busy       <= 1'b1;
    end else begin
      ack  <= '0;
      // A request arriving on the grant edge survives the clear.
      pend <= (pend & ~clr) | req;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant      <= pick;
            gvalid     <= 1'b1;
            rr         <= nxt;
            busy       <= 1'b1;
            pe_rst_out <= 1'b1;
            if (FULL_MASK[pick]) begin
              state <= PE_ON;
            end else begin
              state <= PE_HOLD;
              cnt   <= HOLD_LD;
            end
          end
        end
        PE_ON: begin
          state   <= CORE_HOLD;
          cnt     <= HOLD_LD;
          rst_out <= 1'b1;
        end
        CORE_HOLD: begin
          if (cnt == 8'd0) begin
            state   <= PE_HOLD;
            cnt     <= LAG_LD;
            rst_out <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PE_HOLD: begin
          if (cnt == 8'd0) begin
            state      <= DONE;
            pe_rst_out <= 1'b0;
            if (gvalid) ack <= ONE << grant;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          gvalid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I2C_RST_SEQ_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_count <= 8'd0;
    end else if (state == DONE && gvalid) begin
      if (seq_count != 8'd255) seq_count <= seq_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_rst_sequencer.sv
// Randomised bench for i2c_rst_sequencer against an offset-based model.
// Checks rst_out, pe_rst_out, busy, ack (and seq_count) every cycle.
module tb_i2c_rst_sequencer;
  localparam int N = 3;
  localparam int H = 8;
  localparam int L = 4;
  localparam logic [2:0] FM = 3'b001;
  localparam int PO = 0;
  localparam int FULL = 1;
  localparam int PEO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] ack;
  logic rst_out;
  logic pe_rst_out;
  logic busy;
`ifdef I2C_RST_SEQ_STATUS_EN
  logic [7:0] seq_count;
`endif

  always #5 clk = ~clk;

  i2c_rst_sequencer #(
    .N_REQ(N),
    .FULL_MASK(FM),
    .RST_HOLD(H),
    .PE_LAG(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .ack(ack),
    .rst_out(rst_out),
    .pe_rst_out(pe_rst_out),
    .busy(busy)
`ifdef I2C_RST_SEQ_STATUS_EN
    ,
    .seq_count(seq_count)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  int m_pend, m_rr, m_kind, m_off, m_grant, m_cnt;
  bit m_act, in_rst;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  function automatic int done_off(input int k);
    if (k == PO) return H + L;
    if (k == FULL) return 1 + H + L;
    return H;
  endfunction

  task automatic model_step(input int r);
    int old, g, idx;
    if (in_rst) return;
    old = m_pend;
    if (m_act) begin
      if (m_off == done_off(m_kind) && m_kind != PO)
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_off++;
      if (m_off > done_off(m_kind)) m_act = 0;
    end else if (old != 0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && ((old >> idx) & 1) == 1) g = idx;
      end
      m_pend = old & ~(1 << g);
      m_grant = g;
      m_rr = (g + 1) % N;
      m_kind = ((FM >> g) & 1) == 1 ? FULL : PEO;
      m_off = 0;
      m_act = 1;
    end
    m_pend = m_pend | r;
  endtask

  task automatic check_outputs();
    int er, ep, eb, ea, o;
    if (in_rst) begin
      er = 1; ep = 1; eb = 1; ea = 0;
    end else if (!m_act) begin
      er = 0; ep = 0; eb = 0; ea = 0;
    end else begin
      o = m_off;
      eb = 1;
      ep = (o < done_off(m_kind)) ? 1 : 0;
      if (m_kind == PO) er = (o < H) ? 1 : 0;
      else if (m_kind == FULL) er = (o >= 1 && o < 1 + H) ? 1 : 0;
      else er = 0;
      ea = (m_kind != PO && o == done_off(m_kind)) ? (1 << m_grant) : 0;
    end
    chk("rst_out", rst_out, er);
    chk("pe_rst_out", pe_rst_out, ep);
    chk("busy", busy, eb);
    chk("ack", ack, ea);
`ifdef I2C_RST_SEQ_STATUS_EN
    chk("seq_count", seq_count, in_rst ? 0 : m_cnt);
`endif
  endtask

  task automatic tick(input logic [2:0] r);
    req = r;
    @(posedge clk);
    model_step(int'(r));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    in_rst = 1;
    m_pend = 0; m_rr = 0; m_act = 0; m_cnt = 0;
    #1 check_outputs();
    tick(3'b000);
    tick(3'b000);
    rst_n = 1'b1;
    in_rst = 0;
    m_act = 1; m_kind = PO; m_off = 0;
    #1 check_outputs();
  endtask

  initial begin
    bit hit;
    @(negedge clk);
    do_reset();
    repeat (H + L + 4) tick(3'b000);

    tick(3'b001);
    repeat (20) tick(3'b000);
    tick(3'b010);
    repeat (14) tick(3'b000);
    tick(3'b111);
    repeat (50) tick(3'b000);

    tick(3'b001);
    repeat (3) tick(3'b000);
    tick(3'b001);
    repeat (40) tick(3'b000);

    tick(3'b001);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (m_act && m_kind == FULL && m_off == 5) hit = 1;
      else tick(3'b000);
    end
    chk("abort_reach", hit, 1);
    do_reset();
    repeat (20) tick(3'b000);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick(($urandom_range(0, 6) == 0) ? 3'($urandom) : 3'b000);
    end
    repeat (60) tick(3'b000);

`ifdef I2C_RST_SEQ_STATUS_EN
    do_reset();
    repeat (H + L + 4) tick(3'b000);
    repeat (260) begin
      tick(3'b010);
      repeat (11) tick(3'b000);
    end
    chk("seq_sat", seq_count, 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_rst_sequencer.md
I2C_RST_SEQUENCER -- requirements
Module: i2c_rst_sequencer

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of reset requesters, range 2..8.
REQ-002 SHALL have parameter FULL_MASK, default 3'b001, N_REQ bits: bit i = 1 means source i gets a full (core + PE) reset; bit i = 0 means PE-only.
REQ-003 SHALL have parameter RST_HOLD, default 8: core-reset hold cycles, range 1..255.
REQ-004 SHALL have parameter PE_LAG, default 4: cycles that PE reset is held after core release, range 1..255.
REQ-005 SHALL have port clk  input  1  sole clock; all flops sample on the rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req  input  N_REQ  reset request pulses or levels, one bit per source.
REQ-008 SHALL have port ack  output  N_REQ  one-cycle completion pulse per source.
REQ-009 SHALL have port rst_out  output  1  core reset, active-high; feeds rst of the deglitcher.
REQ-010 SHALL have port pe_rst_out  output  1  PE reset, active-high; feeds pe_rst of the deglitcher.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL OR each req bit into a sticky pending bit at every clock edge, so a 1-cycle pulse is never lost.
REQ-013 SHALL register all outputs; no combinational path from req to any output.
REQ-014 SHALL implement FSM states IDLE, PE_ON, CORE_HOLD, PE_HOLD, DONE.
REQ-015 In IDLE with any pending bit set, SHALL grant one source round-robin, starting after the last granted index (index 0 first after reset); it SHALL clear that pending bit and move to PE_ON if FULL_MASK[grant] = 1, else to PE_HOLD.
REQ-016 PE_ON SHALL last 1 cycle with pe_rst_out = 1 and rst_out = 0, then go to CORE_HOLD (PE enters reset before core).
REQ-017 CORE_HOLD SHALL last exactly RST_HOLD cycles with rst_out = 1 and pe_rst_out = 1, then go to PE_HOLD with counter reload.
REQ-018 PE_HOLD SHALL hold rst_out = 0 and pe_rst_out = 1 for exactly PE_LAG cycles after a full reset, or RST_HOLD cycles for a PE-only grant, then go to DONE.
REQ-019 DONE SHALL last 1 cycle, drive ack[grant] = 1 if the grant is valid, then return to IDLE; IDLE SHALL last at least 1 cycle.
REQ-020 Latency: req high before edge N sets pending at edge N; the FSM leaves IDLE at edge N+1.
REQ-021 Full sequence totals: pe_rst_out high 1 + RST_HOLD + PE_LAG cycles; rst_out high RST_HOLD cycles, fully nested inside the pe_rst_out window.
REQ-022 Simultaneous requests: all are latched; they are serviced one per sequence in round-robin order, never merged.
REQ-023 A req from the currently granted source during its own sequence SHALL re-set its pending bit and cause one further sequence.
REQ-024 Hold counters SHALL be 8-bit, load RST_HOLD−1 or PE_LAG−1, and count down to 0; no wrap.

Reset
REQ-025 While rst_n = 0: rst_out = 1, pe_rst_out = 1, ack = 0, busy = 1, pending = 0, round-robin pointer = 0, state = CORE_HOLD, grant invalid.
REQ-026 After rst_n release, SHALL run a power-on sequence: CORE_HOLD for RST_HOLD cycles, then PE_HOLD for PE_LAG cycles, then DONE with no ack, then IDLE.
REQ-027 rst_n asserted mid-sequence SHALL abort immediately (asynchronously) to the REQ-025 values; lost grants are not acked.

Configuration
REQ-028 With I2C_RST_SEQ_STATUS_EN defined, SHALL add output seq_count [7:0]: increments on each acked DONE, saturates at 255, cleared by rst_n.
REQ-029 Without I2C_RST_SEQ_STATUS_EN, the seq_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Release rst_n with RST_HOLD = 8, PE_LAG = 4 -> rst_out stays high 8 cycles and pe_rst_out 12 cycles after release, no ack pulse, then busy = 0.
REQ-031 1-cycle pulse on req[0] (full) -> pe_rst_out high 13 cycles, rst_out high 8 cycles starting 1 cycle after pe_rst_out, ack[0] pulses once.
REQ-032 1-cycle pulse on req[1] (PE-only) -> pe_rst_out high 8 cycles, rst_out stays 0, ack[1] pulses once.
REQ-033 req = 3'b111 in the same cycle -> three back-to-back sequences in order 0, 1, 2; acks in that order; one IDLE cycle between sequences.
REQ-034 rst_n pulled low in cycle 5 of CORE_HOLD -> rst_out and pe_rst_out are 1 and pending is 0 immediately; no ack; power-on sequence follows release.
REQ-035 With I2C_RST_SEQ_STATUS_EN, 260 single requests -> seq_count reads 255 and holds there.
